// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift/compare plus iterative
// unsigned multiply (shift-add) and divide (restoring), valid/ready on both sides.
module seq_alu #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       aluControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] OutHi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: an op transfers on a rising edge with in_valid & in_ready (IDLE only);
  // a result transfers with out_valid & out_ready (DONE only), after which the
  // unit spends one cycle in IDLE before it can accept again.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [SHW-1:0] CNT_MAX = SHW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] add_res, sub_res, sc_res, sc_hi;
  logic             sc_ovf, sc_dbz, is_iter;
  logic [SHW-1:0]   shamt;

  always_comb begin
    add_res = input1 + input2;
    sub_res = input1 - input2;
    shamt   = input2[SHW-1:0];
    sc_res  = '0;
    sc_hi   = '0;
    sc_ovf  = 1'b0;
    sc_dbz  = 1'b0;
    is_iter = (aluControl == 4'd11) || ((aluControl == 4'd12) && (input2 != '0));
    case (aluControl)
      4'd0: begin
        sc_res = add_res;
        sc_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) && (add_res[WIDTH-1] != input1[WIDTH-1]);
      end
      4'd1: begin
        sc_res = sub_res;
        // ~B+1 has the opposite sign of B except when B is zero or the most negative value
        sc_ovf = (input1[WIDTH-1] == (~input2 + 1'b1) >> (WIDTH-1))
                 && (sub_res[WIDTH-1] != input1[WIDTH-1]);
      end
      4'd2:  sc_res = input1 & input2;
      4'd3:  sc_res = input1 | input2;
      4'd4:  sc_res = input1 ^ input2;
      4'd5:  sc_res = ~(input1 | input2);
      4'd6:  sc_res = {{(WIDTH-1){1'b0}}, $signed(input1) < $signed(input2)};
      4'd7:  sc_res = {{(WIDTH-1){1'b0}}, input1 < input2};
      4'd8:  sc_res = input1 << shamt;
      4'd9:  sc_res = input1 >> shamt;
      4'd10: sc_res = WIDTH'($signed(input1) >>> shamt);
      4'd12: begin
        // only reached as a single-cycle op when the divisor is zero
        sc_res = '1;
        sc_hi  = input1;
        sc_dbz = 1'b1;
      end
      default: sc_res = '0;
    endcase
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] step_acc, step_lo;

  // {acc, lo} is the running product for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh  = {acc_q, lo_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, opnd_q};
    if (is_div_q) begin
      step_acc = div_ge ? (div_sh[WIDTH-1:0] - opnd_q) : div_sh[WIDTH-1:0];
      step_lo  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_iter) begin
            state_d  = S_BUSY;
            cnt_d    = CNT_MAX;
            is_div_d = (aluControl == 4'd12);
            opnd_d   = (aluControl == 4'd12) ? input2 : input1;
            lo_d     = (aluControl == 4'd12) ? input1 : input2;
            acc_d    = '0;
            zero_d   = 1'b0;
            ovf_d    = 1'b0;
            dbz_d    = 1'b0;
          end else begin
            state_d = S_DONE;
            lo_d    = sc_res;
            acc_d   = sc_hi;
            zero_d  = (sc_res == '0);
            ovf_d   = sc_ovf;
            dbz_d   = sc_dbz;
          end
        end
      end
      S_BUSY: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          zero_d  = (step_lo == '0);
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Out         = lo_q;
  assign OutHi       = acc_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH = 16): hand-computed results, latency,
// backpressure and mid-operation reset.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] input1 = '0;
  logic [15:0] input2 = '0;
  logic [3:0]  aluControl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Out, OutHi;
  logic        zero, overflow, div_by_zero;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .input1(input1), .input2(input2), .aluControl(aluControl),
    .out_valid(out_valid), .out_ready(out_ready), .Out(Out), .OutHi(OutHi),
    .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for its result, compare against the scoreboard.
  // lat counts edges from the accepting edge to the first edge that sees out_valid.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, output int lat, output bit busy_ready);
    exp_q.push_back(exp);
    @(negedge clk);
    input1 = a; input2 = b; aluControl = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy_ready = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      input1 = 16'($urandom_range(0, 65535));
      input2 = 16'($urandom_range(0, 65535));
      if (in_ready) busy_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
    check("result", {OutHi, Out}, exp_q.pop_front());
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    bit br;
    logic [15:0] held_lo, held_hi;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", {OutHi, Out}, 32'd0);
    check("rst_flags", {29'd0, zero, overflow, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    // 1. add/sub
    run_op(4'd0, 16'd5, 16'd6, 32'd11, lat, br);
    check("add_lat", 32'(lat), 32'd1);
    check("add_zero", 32'(zero), 32'd0);
    check("add_ovf", 32'(overflow), 32'd0);
    consume();
    run_op(4'd1, 16'd5, 16'd6, 32'h0000_FFFF, lat, br);
    check("sub_ovf", 32'(overflow), 32'd0);
    consume();
    run_op(4'd0, 16'h7FFF, 16'd1, 32'h0000_8000, lat, br);
    check("add_ovf_pos", 32'(overflow), 32'd1);
    consume();
    run_op(4'd1, 16'h8000, 16'd1, 32'h0000_7FFF, lat, br);
    check("sub_ovf_neg", 32'(overflow), 32'd1);
    consume();

    // 2. multiply
    run_op(4'd11, 16'd300, 16'd300, 32'h0001_5F90, lat, br);
    check("mul_lat", 32'(lat), 32'd17);
    check("mul_busy_in_ready", 32'(br), 32'd0);
    check("mul_zero", 32'(zero), 32'd0);
    consume();
    run_op(4'd11, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, lat, br);
    consume();

    // 3. divide
    run_op(4'd12, 16'd100, 16'd7, {16'd2, 16'd14}, lat, br);
    check("div_lat", 32'(lat), 32'd17);
    check("div_dbz", 32'(div_by_zero), 32'd0);
    consume();
    run_op(4'd12, 16'hFFFF, 16'h0010, {16'h000F, 16'h0FFF}, lat, br);
    consume();
    run_op(4'd12, 16'd5, 16'd0, {16'd5, 16'hFFFF}, lat, br);
    check("div0_lat", 32'(lat), 32'd1);
    check("div0_flag", 32'(div_by_zero), 32'd1);
    consume();

    // 4. compare, shifts, logic, reserved
    run_op(4'd6, 16'hFFFF, 16'd1, 32'd1, lat, br);          consume();
    run_op(4'd7, 16'hFFFF, 16'd1, 32'd0, lat, br);
    check("sltu_zero", 32'(zero), 32'd1);                   consume();
    run_op(4'd10, 16'h8000, 16'd15, 32'h0000_FFFF, lat, br); consume();
    run_op(4'd9, 16'h8000, 16'h00F3, 32'h0000_1000, lat, br); consume();
    run_op(4'd8, 16'h0003, 16'd4, 32'h0000_0030, lat, br);  consume();
    run_op(4'd2, 16'hF0F0, 16'h3C3C, 32'h0000_3030, lat, br); consume();
    run_op(4'd3, 16'hF0F0, 16'h3C3C, 32'h0000_FCFC, lat, br); consume();
    run_op(4'd4, 16'hF0F0, 16'h3C3C, 32'h0000_CCCC, lat, br); consume();
    run_op(4'd5, 16'hF0F0, 16'h3C3C, 32'h0000_0303, lat, br); consume();
    run_op(4'd13, 16'h1234, 16'h5678, 32'd0, lat, br);      consume();
    run_op(4'd1, 16'd6, 16'd6, 32'd0, lat, br);
    check("sub_zero", 32'(zero), 32'd1);
    consume();

    // 5. backpressure
    run_op(4'd11, 16'd300, 16'd300, 32'h0001_5F90, lat, br);
    held_lo = 16'h5F90; held_hi = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold", {OutHi, Out}, {held_hi, held_lo});
    end
    consume();

    // 6. reset in the middle of a multiply
    @(negedge clk);
    input1 = 16'd300; input2 = 16'd300; aluControl = 4'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_out", {OutHi, Out}, 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_flags", {29'd0, zero, overflow, div_by_zero}, 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) check("abort_stray_valid", 32'(out_valid), 32'd0);
    end
    run_op(4'd0, 16'd1, 16'd1, 32'd2, lat, br);
    check("post_rst_lat", 32'(lat), 32'd1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
